cordic_controller: RTL and testbench
====================================

Name: cordic_controller

Overview:
Sequencer for the iterative `cordic` core. It accepts one job per valid/ready handshake: initial x/y/z, rotation system and control mode. It then loads the core, issues one iterate strobe per cycle with the correct shift index, and stops early if the core reports overflow. Results are returned on a valid/ready response channel. It sits between the accelerator's register/bus front end and the `cordic` core, and replaces the testbench sequencer in real use.

Parameters:
- p_WIDTH, 32, width of x/y (fixed point) and z (angle word).
- p_NUM_ITER, 15, number of distinct shift indices per job; must be in 1..31.
- p_IDX_W, 5, width of the shift-index and iteration-count fields; must satisfy 2^p_IDX_W > p_NUM_ITER+2.

Ports:
- clk, in, 1: single clock; everything is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: job request is valid.
- req_ready, out, 1: controller can accept a job.
- req_system, in, 1: 1 = circular, 0 = hyperbolic.
- req_mode, in, 1: 1 = rotation, 0 = vectoring.
- req_x / req_y / req_z, in, p_WIDTH each: initial x, y, z.
- core_load, out, 1: one-cycle strobe that loads core_x_in/y_in/z_in into the core.
- core_x_in / core_y_in / core_z_in, out, p_WIDTH each: initial values, registered from the request.
- core_system / core_mode, out, 1 each: configuration held stable for the whole job.
- core_iterate, out, 1: one iteration is performed on each cycle this is high.
- core_shift, out, p_IDX_W: shift index for the current iteration.
- core_x_out / core_y_out / core_z_out, in, p_WIDTH each: current core state.
- core_overflow, in, 1: core reports overflow on the iteration just strobed.
- rsp_valid, out, 1: result is valid.
- rsp_ready, in, 1: consumer accepts the result.
- rsp_x / rsp_y / rsp_z, out, p_WIDTH each: final core state.
- rsp_overflow, out, 1: job terminated because of overflow.
- rsp_iters, out, p_IDX_W: number of iterate strobes issued for the job.
- busy, out, 1: high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, LOAD, ITER, DONE. Reset puts the FSM in IDLE.
- Reset values: all outputs 0, except req_ready = 1. Reset clears all registers, including in-flight data, mid-job; no response is produced for an aborted job.
- IDLE: req_ready = 1. When req_valid & req_ready, capture req_* into registers and go to LOAD.
- LOAD (exactly 1 cycle): core_load = 1; iteration counter cleared; go to ITER.
- ITER: core_iterate = 1 every cycle; core_shift comes from the schedule.
  - Circular schedule: shifts 0..p_NUM_ITER-1.
  - Hyperbolic schedule: shifts 1..p_NUM_ITER.
  - core_overflow is sampled in the same cycle as the iterate it qualifies. If it is 1, or if this is the last scheduled iterate, go to DONE.
  - rsp_iters counts the iterates issued, including the one that overflowed.
- DONE:
  - On entry, capture core_*_out into rsp_* in the same edge that leaves ITER (the core updates on that edge, so capture occurs the cycle after, i.e. on entry to DONE).
  - Assert rsp_valid. Hold all rsp_* stable until rsp_valid & rsp_ready, then go to IDLE.
  - req_ready = 0, so no new job is accepted the same cycle; the next job is accepted no earlier than the cycle after the response handshake.
- Latency with no overflow: request handshake at cycle T → core_load at T+1 → iterates at T+2..T+1+N → rsp_valid at T+2+N, where N = schedule length.
- core_system / core_mode / core_*_in are registered and constant from LOAD through DONE.
- The core is never strobed outside ITER: core_load and core_iterate are mutually exclusive.

Optional Feature:
CORDIC_HYP_REPEAT_EN
- Defined: the hyperbolic schedule repeats shifts 4 and 13 (only those ≤ p_NUM_ITER), which is required for hyperbolic convergence. With default parameters: 1,2,3,4,4,5,…,13,13,14,15, giving N = 17.
- Undefined: no repeats; hyperbolic N = p_NUM_ITER.
- The circular schedule is unaffected in both cases.

Decomposition:
- Package cordic_pkg:
  - FSM state enum.
  - Constants SYS_CIRCULAR = 1, SYS_HYPERBOLIC = 0, MODE_ROTATION = 1, MODE_VECTORING = 0.
  - Repeat-index constants 4 and 13.
  - Gain constants 0.6072529350092496 (circular) and 1.2051363584457304 (hyperbolic) for bench use.
- Sub-module cordic_shift_sched: counter plus repeat flag. Inputs start/advance/system; outputs shift and last.

Test Plan:
- Circular rotation, x=0.6072529350092496, y=0, z=45°, rsp_ready=1 → core_load at T+1, 15 iterates with shifts 0..14, rsp_valid at T+17, rsp_x≈rsp_y≈0.7071 (err < 1e-4), rsp_overflow=0, rsp_iters=15.
- Hyperbolic vectoring x=1, y=0.5, with the macro defined → shift sequence includes 4 and 13 twice each; rsp_iters=17; rsp_z≈atanh(0.5)=0.5493 rad. Without the macro → rsp_iters=15.
- Core model asserts core_overflow on the 4th iterate → core_iterate stops next cycle; rsp_overflow=1; rsp_iters=4.
- Hold rsp_ready=0 for 10 cycles in DONE → rsp_* stable; req_ready=0; a pending req_valid is not accepted until the cycle after the rsp handshake.
- Assert rst_n=0 during ITER (iteration 7) → all outputs return to reset values immediately; no rsp_valid; next job runs the full schedule.
- Back-to-back jobs with req_valid held high → second core_load occurs exactly 2 cycles after the first response handshake.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic controller and its schedule generator.
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

    localparam logic SYS_CIRCULAR   = 1'b1;
    localparam logic SYS_HYPERBOLIC = 1'b0;
    localparam logic MODE_ROTATION  = 1'b1;
    localparam logic MODE_VECTORING = 1'b0;

    // Hyperbolic iterations that must be repeated for convergence.
    localparam int REP_IDX_A = 4;
    localparam int REP_IDX_B = 13;

    localparam real GAIN_CIRC = 0.6072529350092496;
    localparam real GAIN_HYP  = 1.2051363584457304;

endpackage

// File: rtl/cordic_shift_sched.sv
// Shift-index schedule: circular 0..N-1, hyperbolic 1..N.
// With CORDIC_HYP_REPEAT_EN defined, hyperbolic shifts 4 and 13 are issued twice.
module cordic_shift_sched
    import cordic_pkg::*;
#(
    parameter int p_NUM_ITER = 15,
    parameter int p_IDX_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               advance,
    input  logic               system,
    output logic [p_IDX_W-1:0] shift,
    output logic               last
);
    localparam logic [p_IDX_W-1:0] ONE       = p_IDX_W'(1);
    localparam logic [p_IDX_W-1:0] LAST_CIRC = p_IDX_W'(p_NUM_ITER - 1);
    localparam logic [p_IDX_W-1:0] LAST_HYP  = p_IDX_W'(p_NUM_ITER);

    logic [p_IDX_W-1:0] shift_q, shift_d;
    logic               rep_due;

`ifdef CORDIC_HYP_REPEAT_EN
    logic rep_q;

    // First visit of a repeat index holds the shift for one more iterate.
    assign rep_due = (system == SYS_HYPERBOLIC) && !rep_q &&
                     (int'(shift_q) == REP_IDX_A || int'(shift_q) == REP_IDX_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rep_q <= 1'b0;
        else if (start)   rep_q <= 1'b0;
        else if (advance) rep_q <= rep_due;
    end
`else
    assign rep_due = 1'b0;
`endif

    always_comb begin
        shift_d = shift_q;
        if (start)
            shift_d = (system == SYS_CIRCULAR) ? '0 : ONE;
        else if (advance && !rep_due)
            shift_d = shift_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shift_q <= '0;
        else        shift_q <= shift_d;
    end

    assign shift = shift_q;
    assign last  = (shift_q == ((system == SYS_CIRCULAR) ? LAST_CIRC : LAST_HYP)) && !rep_due;

endmodule

// File: rtl/cordic_controller.sv
// Job sequencer for the iterative cordic core: load, strobe the schedule, return results.
// Build with CORDIC_HYP_REPEAT_EN to repeat shifts 4/13 in the hyperbolic schedule.
module cordic_controller
    import cordic_pkg::*;
#(
    parameter int p_WIDTH    = 32,
    parameter int p_NUM_ITER = 15,
    parameter int p_IDX_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_system,
    input  logic               req_mode,
    input  logic [p_WIDTH-1:0] req_x,
    input  logic [p_WIDTH-1:0] req_y,
    input  logic [p_WIDTH-1:0] req_z,
    output logic               core_load,
    output logic [p_WIDTH-1:0] core_x_in,
    output logic [p_WIDTH-1:0] core_y_in,
    output logic [p_WIDTH-1:0] core_z_in,
    output logic               core_system,
    output logic               core_mode,
    output logic               core_iterate,
    output logic [p_IDX_W-1:0] core_shift,
    input  logic [p_WIDTH-1:0] core_x_out,
    input  logic [p_WIDTH-1:0] core_y_out,
    input  logic [p_WIDTH-1:0] core_z_out,
    input  logic               core_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [p_WIDTH-1:0] rsp_x,
    output logic [p_WIDTH-1:0] rsp_y,
    output logic [p_WIDTH-1:0] rsp_z,
    output logic               rsp_overflow,
    output logic [p_IDX_W-1:0] rsp_iters,
    output logic               busy
);
    localparam logic [p_IDX_W-1:0] ONE = p_IDX_W'(1);

    state_e             state_q;
    logic               req_ready_q, load_q, iter_q, rsp_valid_q, busy_q, cap_q, ovf_q;
    logic               sys_q, mode_q;
    logic [p_WIDTH-1:0] x_in_q, y_in_q, z_in_q, rsp_x_q, rsp_y_q, rsp_z_q;
    logic [p_IDX_W-1:0] iters_q, sched_shift;
    logic               sched_last;

    cordic_shift_sched #(.p_NUM_ITER(p_NUM_ITER), .p_IDX_W(p_IDX_W)) u_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state_q == LOAD),
        .advance (iter_q),
        .system  (sys_q),
        .shift   (sched_shift),
        .last    (sched_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            load_q      <= 1'b0;
            iter_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cap_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sys_q       <= 1'b0;
            mode_q      <= 1'b0;
            x_in_q      <= '0;
            y_in_q      <= '0;
            z_in_q      <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_z_q     <= '0;
            iters_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    sys_q       <= req_system;
                    mode_q      <= req_mode;
                    x_in_q      <= req_x;
                    y_in_q      <= req_y;
                    z_in_q      <= req_z;
                    req_ready_q <= 1'b0;
                    load_q      <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= LOAD;
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    iter_q  <= 1'b1;
                    iters_q <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= ITER;
                end
                ITER: begin
                    iters_q <= iters_q + ONE;
                    if (core_overflow || sched_last) begin
                        ovf_q       <= core_overflow;
                        iter_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Core settles on the edge leaving ITER, so capture in the first DONE cycle.
                    if (!cap_q) begin
                        rsp_x_q <= core_x_out;
                        rsp_y_q <= core_y_out;
                        rsp_z_q <= core_z_out;
                    end
                    cap_q <= 1'b1;
                    if (rsp_ready) begin
                        cap_q       <= 1'b0;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign core_load    = load_q;
    assign core_iterate = iter_q;
    assign core_shift   = sched_shift;
    assign core_system  = sys_q;
    assign core_mode    = mode_q;
    assign core_x_in    = x_in_q;
    assign core_y_in    = y_in_q;
    assign core_z_in    = z_in_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_overflow = ovf_q;
    assign rsp_iters    = iters_q;
    assign busy         = busy_q;

    // Before the capture register fills, the idle core already holds the final state.
    assign rsp_x = (rsp_valid_q && !cap_q) ? core_x_out : rsp_x_q;
    assign rsp_y = (rsp_valid_q && !cap_q) ? core_y_out : rsp_y_q;
    assign rsp_z = (rsp_valid_q && !cap_q) ? core_z_out : rsp_z_q;

endmodule

// File: tb/tb_cordic_controller.sv
// Self-checking bench for cordic_controller with a behavioural cordic core and schedule model.
module tb_cordic_controller;
    import cordic_pkg::*;

    localparam int  NI = 15;
    localparam real SC = 536870912.0;   // 2^29: Q2.29 for x, y and z (radians)

    typedef struct packed { logic [31:0] x, y, z; } st_t;

    logic clk = 1'b0;
    logic rst_n, req_valid, req_ready, req_system, req_mode;
    logic [31:0] req_x, req_y, req_z, core_x_in, core_y_in, core_z_in;
    logic core_load, core_system, core_mode, core_iterate, core_overflow;
    logic [4:0] core_shift, rsp_iters;
    logic [31:0] core_x_out, core_y_out, core_z_out, rsp_x, rsp_y, rsp_z;
    logic rsp_valid, rsp_ready, rsp_overflow, busy;

    cordic_controller dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_system(req_system), .req_mode(req_mode), .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .core_load(core_load), .core_x_in(core_x_in), .core_y_in(core_y_in), .core_z_in(core_z_in),
        .core_system(core_system), .core_mode(core_mode), .core_iterate(core_iterate),
        .core_shift(core_shift), .core_x_out(core_x_out), .core_y_out(core_y_out),
        .core_z_out(core_z_out), .core_overflow(core_overflow), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .rsp_overflow(rsp_overflow), .rsp_iters(rsp_iters), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic signed [31:0] atan_tab [0:31];
    logic signed [31:0] atanh_tab [0:31];
    int exp_sh [0:63];

    // ---- behavioural core and event recorder ----
    st_t cs = '0;
    int  tb_it = 0, ovf_at = 0, cyc = 0, excl_err = 0;
    logic rv_prev = 1'b0;
    int hs_req[$], load_c[$], iter_c[$], shift_q[$], rv_rise[$], rsp_hs[$];

    function automatic st_t step(input st_t a, input bit sys, input bit mode, input int s);
        logic signed [31:0] ax, ay, az, xs, ys, e;
        bit dpos;
        st_t r;
        ax = a.x; ay = a.y; az = a.z;
        xs = ax >>> s; ys = ay >>> s;
        e = sys ? atan_tab[s] : atanh_tab[s];
        dpos = mode ? (az >= 0) : (ay < 0);
        if (dpos) begin
            r.x = sys ? ax - ys : ax + ys; r.y = ay + xs; r.z = az - e;
        end else begin
            r.x = sys ? ax + ys : ax - ys; r.y = ay - xs; r.z = az + e;
        end
        return r;
    endfunction

    assign core_x_out = cs.x;
    assign core_y_out = cs.y;
    assign core_z_out = cs.z;
    assign core_overflow = core_iterate && (ovf_at != 0) && (tb_it == ovf_at - 1);

    always @(posedge clk) begin
        if (req_valid && req_ready) hs_req.push_back(cyc);
        if (core_load) load_c.push_back(cyc);
        if (core_load && core_iterate) excl_err++;
        if (core_iterate) begin shift_q.push_back(int'(core_shift)); iter_c.push_back(cyc); end
        if (rsp_valid && !rv_prev) rv_rise.push_back(cyc);
        if (rsp_valid && rsp_ready) rsp_hs.push_back(cyc);
        rv_prev <= rsp_valid;
        if (core_load) begin
            cs <= {core_x_in, core_y_in, core_z_in};
            tb_it <= 0;
        end else if (core_iterate) begin
            cs <= step(cs, core_system, core_mode, int'(core_shift));
            tb_it <= tb_it + 1;
        end
        cyc++;
    end

    // ---- reference schedule, straight from the rules ----
    function automatic int build_sched(input bit sys);
        int n;
        n = 0;
        if (sys) begin
            for (int s = 0; s < NI; s++) begin exp_sh[n] = s; n++; end
        end else begin
            for (int s = 1; s <= NI; s++) begin
                exp_sh[n] = s; n++;
`ifdef CORDIC_HYP_REPEAT_EN
                if (s == 4 || s == 13) begin exp_sh[n] = s; n++; end
`endif
            end
        end
        return n;
    endfunction

    function automatic real to_r(input logic [31:0] v);
        return real'($signed(v)) / SC;
    endfunction

    function automatic logic [31:0] to_fx(input real r);
        return $rtoi(r * SC);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
        bit ok;
        ok = (obs - exp < tol) && (exp - obs < tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: got %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ctl"}, {58'd0, req_ready, busy, core_load, core_iterate, rsp_valid, rsp_overflow}, 64'b100000);
        chk({tag, "_idx"}, {54'd0, rsp_iters, core_shift}, 64'd0);
        chk({tag, "_rsp"}, {32'd0, rsp_x | rsp_y | rsp_z}, 64'd0);
        chk({tag, "_cin"}, {30'd0, core_system, core_mode, core_x_in | core_y_in | core_z_in}, 64'd0);
    endtask

    // ---- job driver: expectations are set here, called on a falling edge ----
    bit e_sys, e_mode, e_ovf;
    logic [31:0] e_x, e_y, e_z, got_x, got_y, got_z;
    int e_n, T_g, H_g, nh0;
    st_t e_res;

    task automatic issue(input bit sys, input bit mode, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input int ovf, input bit keep);
        int full, nhs;
        full  = build_sched(sys);
        e_ovf = (ovf != 0) && (ovf <= full);
        e_n   = e_ovf ? ovf : full;
        e_res = {x, y, z};
        for (int i = 0; i < e_n; i++) e_res = step(e_res, sys, mode, exp_sh[i]);
        e_sys = sys; e_mode = mode; e_x = x; e_y = y; e_z = z;
        ovf_at = ovf;
        req_system = sys; req_mode = mode; req_x = x; req_y = y; req_z = z; req_valid = 1'b1;
        shift_q.delete(); iter_c.delete();
        nhs = hs_req.size(); nh0 = rsp_hs.size();
        for (int i = 0; i < 40 && hs_req.size() == nhs; i++) @(negedge clk);
        chk("req_accept", hs_req.size(), nhs + 1);
        T_g = hs_req[$];
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic finish(input int stall, input bit pend);
        int nhs;
        rsp_ready = (stall == 0);
        for (int i = 0; i < 100 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        got_x = rsp_x; got_y = rsp_y; got_z = rsp_z;
        chk("rsp_iters", rsp_iters, e_n);
        chk("rsp_overflow", rsp_overflow, e_ovf);
        chk("rsp_x", rsp_x, e_res.x);
        chk("rsp_y", rsp_y, e_res.y);
        chk("rsp_z", rsp_z, e_res.z);
        chk("done_ready_busy", {req_ready, busy}, 2'b01);
        chk("cfg_hold", {core_system, core_mode}, {e_sys, e_mode});
        chk("cin_hold", {core_x_in, core_y_in}, {e_x, e_y});
        chk("zin_hold", core_z_in, e_z);
        chk("load_cycle", load_c[$], T_g + 1);
        chk("iter_count", iter_c.size(), e_n);
        if (iter_c.size() > 0) begin
            chk("first_iter_cycle", iter_c[0], T_g + 2);
            chk("last_iter_cycle", iter_c[$], T_g + 1 + e_n);
        end
        for (int i = 0; i < e_n && i < shift_q.size(); i++) chk("shift_seq", shift_q[i], exp_sh[i]);
        if (stall > 0) begin
            if (pend) req_valid = 1'b1;
            nhs = hs_req.size();
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("stall_hold_xy", {rsp_x, rsp_y}, {got_x, got_y});
                chk("stall_ctl", {rsp_valid, req_ready, rsp_z}, {1'b1, 1'b0, got_z});
            end
            chk("stall_no_accept", hs_req.size(), nhs);
            rsp_ready = 1'b1;
        end
        for (int i = 0; i < 20 && rsp_hs.size() == nh0; i++) @(negedge clk);
        chk("rsp_handshake", rsp_hs.size(), nh0 + 1);
        H_g = rsp_hs[$];
        chk("rsp_valid_cycle", rv_rise[$], T_g + 2 + e_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real v;
        bit rs, rm;
        logic [31:0] rx, ry, rz;
        int ro, rstl, hprev, nrv;
        v = 1.0;
        for (int s = 0; s < 32; s++) begin
            atan_tab[s]  = $rtoi($atan(v) * SC);
            atanh_tab[s] = (s == 0) ? 0 : $rtoi(0.5 * $ln((1.0 + v) / (1.0 - v)) * SC);
            v = v * 0.5;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_system = 1'b0; req_mode = 1'b0;
        req_x = '0; req_y = '0; req_z = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // circular rotation by 45 degrees from the pre-scaled unit vector
        issue(SYS_CIRCULAR, MODE_ROTATION, to_fx(GAIN_CIRC), 32'd0, to_fx(0.7853981633974483), 0, 1'b0);
        finish(0, 1'b0);
        chk("circ_iters", rsp_iters, 15);
        chk_near("circ_x", to_r(got_x), 0.7071067811865476, 1e-4);
        chk_near("circ_y", to_r(got_y), 0.7071067811865476, 1e-4);

        // hyperbolic vectoring: z converges to atanh(y/x)
        issue(SYS_HYPERBOLIC, MODE_VECTORING, to_fx(1.0), to_fx(0.5), 32'd0, 0, 1'b0);
        finish(0, 1'b0);
`ifdef CORDIC_HYP_REPEAT_EN
        chk("hyp_iters", {27'd0, rsp_iters}, 17);
        chk_near("hyp_z", to_r(got_z), 0.5493061443340549, 1e-4);
`else
        chk("hyp_iters", {27'd0, rsp_iters}, 15);
`endif

        // overflow on the 4th iterate terminates the job
        issue(SYS_CIRCULAR, MODE_ROTATION, to_fx(0.5), to_fx(0.25), to_fx(0.3), 4, 1'b0);
        finish(0, 1'b0);
        chk("ovf_iters_flag", {rsp_overflow, rsp_iters}, {1'b1, 5'd4});
        ovf_at = 0;

        // consumer stalls 10 cycles while another request is pending
        issue(SYS_HYPERBOLIC, MODE_ROTATION, to_fx(1.2), to_fx(-0.1), to_fx(-0.4), 0, 1'b0);
        finish(10, 1'b1);
        hprev = H_g;
        issue(SYS_HYPERBOLIC, MODE_ROTATION, to_fx(1.2), to_fx(-0.1), to_fx(-0.4), 0, 1'b0);
        chk("pending_accept_cycle", T_g, hprev + 1);
        finish(0, 1'b0);

        // reset mid-job, after the 7th iterate
        issue(SYS_CIRCULAR, MODE_VECTORING, to_fx(0.9), to_fx(0.4), 32'd0, 0, 1'b0);
        for (int i = 0; i < 40 && shift_q.size() < 7; i++) @(negedge clk);
        chk("abort_point", shift_q.size(), 7);
        rst_n = 1'b0;
        #1;
        chk_rst("abort");
        @(negedge clk);
        rst_n = 1'b1;
        nrv = rv_rise.size();
        repeat (25) @(negedge clk);
        chk("abort_no_rsp", rv_rise.size(), nrv);
        issue(SYS_CIRCULAR, MODE_VECTORING, to_fx(0.9), to_fx(0.4), 32'd0, 0, 1'b0);
        finish(0, 1'b0);

        // back-to-back with req_valid held high
        issue(SYS_CIRCULAR, MODE_ROTATION, to_fx(0.3), to_fx(0.6), to_fx(-0.5), 0, 1'b1);
        finish(0, 1'b0);
        hprev = H_g;
        issue(SYS_CIRCULAR, MODE_ROTATION, to_fx(0.3), to_fx(0.6), to_fx(-0.5), 0, 1'b0);
        finish(0, 1'b0);
        chk("b2b_load_cycle", load_c[$], hprev + 2);

        // randomized jobs
        for (int j = 0; j < 8; j++) begin
            rs = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rx = $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
            ry = $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
            rz = $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
            ro = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : 0;
            rstl = int'($urandom_range(0, 3));
            issue(rs, rm, rx, ry, rz, ro, 1'b0);
            finish(rstl, 1'b0);
        end
        ovf_at = 0;

        chk("load_iter_exclusive", excl_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
